// File: rtl/bomb_scheduler.sv
`timescale 1ns/1ps
// bomb_scheduler
// Owns the bomb slots. Arbitrates placement requests from the two players,
// allocates the lowest free slot, and runs each bomb through its fuse and
// blast phases, ticking once per frame on EOF.
//
// Ports:
//   clk, reset (async, active-high), EOF (per-frame tick)
//   req0/req1, pos0X/pos0Y/pos1X/pos1Y : placement requests with coordinates
//   gnt0/gnt1, deny0/deny1             : one-cycle response pulses
//   slot_state  [2*NSLOT]  : per slot 00 free, 01 armed, 10 blasting
//   slot_x/slot_y [11*NSLOT] : packed signed coordinates per slot
//   slot_owner  [NSLOT]    : owning player (valid when slot not free)
//   blast_start [NSLOT]    : one-cycle pulse on entry to blasting
//
// Slot states:
//   state    | meaning
//   S_FREE   | slot unused, available for allocation
//   S_ARMED  | bomb placed, fuse counting down on EOF
//   S_BLAST  | blast active, counting down on EOF, then back to free
module bomb_scheduler #(
  parameter int NSLOT        = 4,
  parameter int MAXP         = 2,
  parameter int FUSE_FRAMES  = 120,
  parameter int BLAST_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      EOF,
  input  logic                      req0,
  input  logic                      req1,
  input  logic signed [10:0]        pos0X,
  input  logic signed [10:0]        pos0Y,
  input  logic signed [10:0]        pos1X,
  input  logic signed [10:0]        pos1Y,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic                      deny0,
  output logic                      deny1,
  output logic [2*NSLOT-1:0]        slot_state,
  output logic [11*NSLOT-1:0]       slot_x,
  output logic [11*NSLOT-1:0]       slot_y,
  output logic [NSLOT-1:0]          slot_owner,
  output logic [NSLOT-1:0]          blast_start
);

  localparam int CMAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FUSE_LD  = CW'(FUSE_FRAMES);
  localparam logic [CW-1:0] BLAST_LD = CW'(BLAST_FRAMES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_FREE  = 2'b00,
    S_ARMED = 2'b01,
    S_BLAST = 2'b10
  } slot_st_e;

  slot_st_e           st_q    [NSLOT];
  slot_st_e           st_d    [NSLOT];
  logic [CW-1:0]      cnt_q   [NSLOT];
  logic [CW-1:0]      cnt_d   [NSLOT];
  logic signed [10:0] x_q     [NSLOT];
  logic signed [10:0] x_d     [NSLOT];
  logic signed [10:0] y_q     [NSLOT];
  logic signed [10:0] y_d     [NSLOT];
  logic [NSLOT-1:0]   owner_q, owner_d;
  logic [NSLOT-1:0]   blast_q, blast_d;
  logic               rr_q, rr_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               deny0_q, deny0_d, deny1_q, deny1_d;

  logic               elig0, elig1, sel_valid, sel_p;
  logic signed [10:0] req_x, req_y;
  int                 live_cnt;
  logic               dup_hit, free_found, do_grant;
  logic [NSLOT-1:0]   free_oh;

  // Request decision, made purely from registered slot state so a slot freed
  // on this edge only becomes allocatable on the next decision.
  always_comb begin
    elig0      = req0 & ~gnt0_q & ~deny0_q;
    elig1      = req1 & ~gnt1_q & ~deny1_q;
    sel_valid  = elig0 | elig1;
    sel_p      = (elig0 & elig1) ? rr_q : elig1;
    req_x      = sel_p ? pos1X : pos0X;
    req_y      = sel_p ? pos1Y : pos0Y;
    live_cnt   = 0;
    dup_hit    = 1'b0;
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (st_q[i] != S_FREE) begin
        if (owner_q[i] == sel_p) live_cnt = live_cnt + 1;
        if (x_q[i] == req_x && y_q[i] == req_y) dup_hit = 1'b1;
      end else if (!free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
    do_grant = sel_valid & (live_cnt < MAXP) & ~dup_hit & free_found;
    gnt0_d   = sel_valid & ~sel_p &  do_grant;
    deny0_d  = sel_valid & ~sel_p & ~do_grant;
    gnt1_d   = sel_valid &  sel_p &  do_grant;
    deny1_d  = sel_valid &  sel_p & ~do_grant;
    rr_d     = sel_valid ? ~sel_p : rr_q;
  end

  // Per-slot sequencing. A newly granted slot was free in registered state,
  // so it never takes an EOF tick in its grant cycle.
  always_comb begin
    owner_d = owner_q;
    blast_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      x_d[i]   = x_q[i];
      y_d[i]   = y_q[i];
      if (do_grant && free_oh[i]) begin
        st_d[i]    = S_ARMED;
        cnt_d[i]   = FUSE_LD;
        owner_d[i] = sel_p;
        x_d[i]     = req_x;
        y_d[i]     = req_y;
      end else if (EOF && st_q[i] != S_FREE) begin
        if (cnt_q[i] == CNT_ONE) begin
          if (st_q[i] == S_ARMED) begin
            st_d[i]    = S_BLAST;
            cnt_d[i]   = BLAST_LD;
            blast_d[i] = 1'b1;
          end else begin
            st_d[i]  = S_FREE;
            cnt_d[i] = '0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]  <= S_FREE;
        cnt_q[i] <= '0;
        x_q[i]   <= '0;
        y_q[i]   <= '0;
      end
      owner_q <= '0;
      blast_q <= '0;
      rr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      deny0_q <= 1'b0;
      deny1_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        x_q[i]   <= x_d[i];
        y_q[i]   <= y_d[i];
      end
      owner_q <= owner_d;
      blast_q <= blast_d;
      rr_q    <= rr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      deny0_q <= deny0_d;
      deny1_q <= deny1_d;
    end
  end

  always_comb begin
    slot_state = '0;
    slot_x     = '0;
    slot_y     = '0;
    for (int i = 0; i < NSLOT; i++) begin
      slot_state[2*i +: 2] = st_q[i];
      slot_x[11*i +: 11]   = x_q[i];
      slot_y[11*i +: 11]   = y_q[i];
    end
  end

  assign slot_owner  = owner_q;
  assign blast_start = blast_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign deny0       = deny0_q;
  assign deny1       = deny1_q;

endmodule

// File: tb/tb_bomb_scheduler.sv
`timescale 1ns/1ps
// tb_bomb_scheduler
// Directed bench for bomb_scheduler with a short fuse (3 frames) and blast
// (2 frames). A frame-level model of the slot pool tracks remaining frames
// per bomb and is compared against every DUT output on each falling edge;
// literal checks at key points pin the model's expectations.
module tb_bomb_scheduler;

  localparam int NSLOT = 4;
  localparam int MAXP  = 2;
  localparam int FUSE  = 3;
  localparam int BLAST = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic EOF = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic signed [10:0] pos0X = '0, pos0Y = '0, pos1X = '0, pos1Y = '0;
  logic gnt0, gnt1, deny0, deny1;
  logic [2*NSLOT-1:0]  slot_state;
  logic [11*NSLOT-1:0] slot_x, slot_y;
  logic [NSLOT-1:0]    slot_owner, blast_start;

  int checks = 0;
  int errors = 0;

  bomb_scheduler #(
    .NSLOT(NSLOT), .MAXP(MAXP), .FUSE_FRAMES(FUSE), .BLAST_FRAMES(BLAST)
  ) dut (
    .clk(clk), .reset(reset), .EOF(EOF),
    .req0(req0), .req1(req1),
    .pos0X(pos0X), .pos0Y(pos0Y), .pos1X(pos1X), .pos1Y(pos1Y),
    .gnt0(gnt0), .gnt1(gnt1), .deny0(deny0), .deny1(deny1),
    .slot_state(slot_state), .slot_x(slot_x), .slot_y(slot_y),
    .slot_owner(slot_owner), .blast_start(blast_start)
  );

  always #5 clk = ~clk;

  // ---------------- frame-level model ----------------
  int                 m_state [NSLOT];   // 0 free, 1 armed, 2 blasting
  int                 m_left  [NSLOT];   // EOF pulses remaining in phase
  int                 m_owner [NSLOT];
  logic signed [10:0] m_x     [NSLOT];
  logic signed [10:0] m_y     [NSLOT];
  bit                 m_bs    [NSLOT];
  bit                 m_gnt   [2];
  bit                 m_deny  [2];
  int                 m_rr;

  bit e0, e1, grant, dup;
  int p, live, fs;
  logic signed [10:0] rx, ry;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        m_state[i] = 0; m_left[i] = 0; m_owner[i] = 0;
        m_x[i] = '0; m_y[i] = '0; m_bs[i] = 0;
      end
      m_gnt = '{0, 0};
      m_deny = '{0, 0};
      m_rr = 0;
    end else begin
      e0 = req0 && !m_gnt[0] && !m_deny[0];
      e1 = req1 && !m_gnt[1] && !m_deny[1];
      m_gnt = '{0, 0};
      m_deny = '{0, 0};
      for (int i = 0; i < NSLOT; i++) m_bs[i] = 0;
      grant = 0;
      fs = -1;
      if (e0 || e1) begin
        p  = (e0 && e1) ? m_rr : (e1 ? 1 : 0);
        rx = (p == 1) ? pos1X : pos0X;
        ry = (p == 1) ? pos1Y : pos0Y;
        live = 0;
        dup = 0;
        for (int i = 0; i < NSLOT; i++)
          if (m_state[i] != 0) begin
            if (m_owner[i] == p) live++;
            if (m_x[i] == rx && m_y[i] == ry) dup = 1;
          end
        for (int i = NSLOT - 1; i >= 0; i--)
          if (m_state[i] == 0) fs = i;
        grant = (live < MAXP) && !dup && (fs >= 0);
        if (grant) m_gnt[p] = 1; else m_deny[p] = 1;
        m_rr = 1 - p;
      end
      if (EOF)
        for (int i = 0; i < NSLOT; i++)
          if (m_state[i] != 0) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              if (m_state[i] == 1) begin
                m_state[i] = 2; m_left[i] = BLAST; m_bs[i] = 1;
              end else begin
                m_state[i] = 0;
              end
            end
          end
      if (grant) begin
        m_state[fs] = 1; m_left[fs] = FUSE; m_owner[fs] = p;
        m_x[fs] = rx; m_y[fs] = ry;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [2*NSLOT-1:0]  exp_state;
  logic [11*NSLOT-1:0] exp_x, exp_y;
  logic [NSLOT-1:0]    exp_owner, exp_bs, live_mask;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        exp_state[2*i +: 2] = 2'(m_state[i]);
        exp_x[11*i +: 11]   = m_x[i];
        exp_y[11*i +: 11]   = m_y[i];
        exp_owner[i]        = m_owner[i][0];
        exp_bs[i]           = m_bs[i];
        live_mask[i]        = (m_state[i] != 0);
      end
      cmp("model_gnt0",  64'(gnt0),  64'(m_gnt[0]));
      cmp("model_gnt1",  64'(gnt1),  64'(m_gnt[1]));
      cmp("model_deny0", 64'(deny0), 64'(m_deny[0]));
      cmp("model_deny1", 64'(deny1), 64'(m_deny[1]));
      cmp("model_state", 64'(slot_state), 64'(exp_state));
      cmp("model_x",     64'(slot_x), 64'(exp_x));
      cmp("model_y",     64'(slot_y), 64'(exp_y));
      cmp("model_owner", 64'(slot_owner & live_mask), 64'(exp_owner & live_mask));
      cmp("model_blast", 64'(blast_start), 64'(exp_bs));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    req0 = 0; req1 = 0; EOF = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic eof_pulse();
    @(negedge clk); EOF = 1;
    @(negedge clk); EOF = 0;
  endtask

  // Raise one request, wait (bounded) for its response, check grant vs deny.
  task automatic req_one(input int pl, input int x, input int y, input bit exp_gnt,
                         input string name);
    bit got;
    @(negedge clk);
    if (pl == 0) begin pos0X = 11'(x); pos0Y = 11'(y); req0 = 1; end
    else         begin pos1X = 11'(x); pos1Y = 11'(y); req1 = 1; end
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pl == 0 ? (gnt0 | deny0) : (gnt1 | deny1)) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no response within 8 cycles", name);
    end else begin
      cmp(name, 64'(pl == 0 ? gnt0 : gnt1), 64'(exp_gnt));
    end
    if (pl == 0) req0 = 0; else req1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    cmp("reset_state", 64'(slot_state), 64'd0);
    cmp("reset_x",     64'(slot_x), 64'd0);
    cmp("reset_resp",  64'({gnt0, gnt1, deny0, deny1, blast_start}), 64'd0);
    reset = 0;

    // Single placement
    req_one(0, 400, 300, 1, "single_gnt0");
    cmp("single_state", 64'(slot_state[1:0]), 64'd1);
    cmp("single_x",     64'(slot_x[10:0]), 64'd400);
    cmp("single_y",     64'(slot_y[10:0]), 64'd300);
    cmp("single_owner", 64'(slot_owner[0]), 64'd0);

    // Fuse/blast with an EOF in the grant cycle that must not count
    do_reset();
    @(negedge clk);
    pos0X = 11'sd50; pos0Y = 11'sd60; req0 = 1; EOF = 1;
    @(negedge clk);
    EOF = 0; req0 = 0;
    cmp("fuse_gnt0",  64'(gnt0), 64'd1);
    cmp("fuse_armed", 64'(slot_state[1:0]), 64'd1);
    eof_pulse();
    eof_pulse();
    cmp("fuse_still_armed", 64'(slot_state[1:0]), 64'd1);
    cmp("fuse_no_blast",    64'(blast_start), 64'd0);
    eof_pulse();
    cmp("fuse_blast_start", 64'(blast_start), 64'd1);
    cmp("fuse_blasting",    64'(slot_state[1:0]), 64'd2);
    eof_pulse();
    cmp("blast_still",      64'(slot_state[1:0]), 64'd2);
    eof_pulse();
    cmp("blast_done",       64'(slot_state[1:0]), 64'd0);

    // Conflict and round-robin
    do_reset();
    @(negedge clk);
    pos0X = 11'sd10; pos0Y = 11'sd10; pos1X = 11'sd20; pos1Y = 11'sd20;
    req0 = 1; req1 = 1;
    @(negedge clk);
    cmp("conf1_gnt0",  64'({gnt0, gnt1}), 64'b10);
    cmp("conf1_slot0", 64'(slot_x[10:0]), 64'd10);
    req0 = 0;
    @(negedge clk);
    cmp("conf1_gnt1",  64'({gnt0, gnt1}), 64'b01);
    cmp("conf1_slot1", 64'(slot_x[21:11]), 64'd20);
    req1 = 0;
    @(negedge clk);
    pos0X = 11'sd30; pos0Y = 11'sd30; pos1X = 11'sd40; pos1Y = 11'sd40;
    req0 = 1; req1 = 1;
    @(negedge clk);
    cmp("conf2_gnt0",  64'({gnt0, gnt1}), 64'b10);
    cmp("conf2_slot2", 64'(slot_x[32:22]), 64'd30);
    req0 = 0;
    @(negedge clk);
    cmp("conf2_gnt1",  64'({gnt0, gnt1}), 64'b01);
    cmp("conf2_slot3", 64'(slot_x[43:33]), 64'd40);
    req1 = 0;

    // Quota and full
    do_reset();
    req_one(0, 100, 100, 1, "quota_p0_a");
    req_one(0, 110, 110, 1, "quota_p0_b");
    req_one(0, 120, 120, 0, "quota_p0_deny");
    req_one(1, 200, 200, 1, "quota_p1_a");
    req_one(1, 210, 210, 1, "quota_p1_b");
    cmp("full_state", 64'(slot_state), 64'h55);
    req_one(1, 220, 220, 0, "full_p1_deny");
    // let every bomb expire, then the first freed slot is reused
    repeat (FUSE + BLAST) eof_pulse();
    cmp("all_free", 64'(slot_state), 64'h00);
    req_one(1, -5, -7, 1, "reuse_p1");
    cmp("reuse_slot0_x",  64'(slot_x[10:0]), 64'(11'h7FB));
    cmp("reuse_owner",    64'(slot_owner[0]), 64'd1);

    // Duplicate position
    do_reset();
    req_one(0, 400, 300, 1, "dup_p0");
    req_one(1, 400, 300, 0, "dup_p1_deny");
    cmp("dup_state", 64'(slot_state), 64'h01);

    // Reset while blasting
    do_reset();
    req_one(0, 5, 5, 1, "rstb_place");
    repeat (FUSE) eof_pulse();
    cmp("rstb_blasting", 64'(slot_state[1:0]), 64'd2);
    @(negedge clk);
    #2 reset = 1;
    #1;
    cmp("rstb_async_state", 64'(slot_state), 64'd0);
    cmp("rstb_async_xy",    64'({slot_x, slot_y}), 64'd0);
    cmp("rstb_async_misc",  64'({gnt0, gnt1, deny0, deny1, slot_owner, blast_start}), 64'd0);
    @(negedge clk);
    reset = 0;
    req_one(0, 7, 7, 1, "rstb_regrant");
    cmp("rstb_slot0", 64'(slot_state[1:0]), 64'd1);
    cmp("rstb_x",     64'(slot_x[10:0]), 64'd7);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
